pcs_block_encoder_mb: RTL

//  Parametrised 64B/66B TX encoder for 40/100GBASE-R (IEEE 802.3 82.2.3.3). Sits between MAC TX and scrambler.

---
 rtl/pcs_pkg.sv | 16 +
 rtl/pcs_block_encoder_mb_if.sv | 16 +
 rtl/pcs_blk_enc_lane.sv | 33 +++
 rtl/pcs_block_encoder_mb.sv | 56 +++++
 4 files changed

// File: rtl/pcs_pkg.sv
// pcs_pkg: shared block codes and 64B/66B field constants for the PCS TX encoder.
package pcs_pkg;
    typedef enum logic [3:0] {
        IDLE, START, DATA,
        TERM0, TERM1, TERM2, TERM3, TERM4, TERM5, TERM6, TERM7,
        ERROR
    } blk_code_e;
    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;
    localparam logic [6:0] CTRL_IDLE = 7'h00;
    localparam logic [6:0] CTRL_ERR = 7'h1E;
    localparam logic [7:0] TYPE_IDLE = 8'h1E;
    localparam logic [7:0] TYPE_START = 8'h78;
    // Indexed by the number of data bytes ahead of the terminate character.
    localparam logic [7:0][7:0] TERM_TYPES = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};
endpackage

// File: rtl/pcs_block_encoder_mb_if.sv
// pcs_block_encoder_mb_if: MAC-side input beat and scrambler-side output beat of the block encoder.
interface pcs_block_encoder_mb_if #(parameter int NUM_BLOCKS = 1, parameter int CNT_W = 16);
    logic in_valid;
    logic in_ready;
    logic [64*NUM_BLOCKS-1:0] data_in;
    logic [8*NUM_BLOCKS-1:0] valid_bytes;
    logic [NUM_BLOCKS-1:0] err_in;
    logic out_valid;
    logic out_ready;
    logic [66*NUM_BLOCKS-1:0] block_out;
    logic [CNT_W-1:0] err_count;
    modport master(output in_valid, data_in, valid_bytes, err_in, out_ready,
                   input in_ready, out_valid, block_out, err_count);
    modport slave(input in_valid, data_in, valid_bytes, err_in, out_ready,
                  output in_ready, out_valid, block_out, err_count);
endinterface

// File: rtl/pcs_blk_enc_lane.sv
// pcs_blk_enc_lane: classifies one 64-bit word against the running idle/data state and builds its 66b block.
module pcs_blk_enc_lane
    import pcs_pkg::*;
(
    input  logic        state_in,
    input  logic [63:0] data,
    input  logic [7:0]  mask,
    input  logic        err,
    output blk_code_e   code,
    output logic [65:0] block,
    output logic        state_out
);
    logic [2:0] k;
    logic run;
    logic [55:0] keep;
    logic [55:0] tdata;
    always_comb begin
        k = 3'($countones(mask));
        run = ((mask & (mask + 8'd1)) == 8'd0) && mask != 8'hFF;
        keep = '0;
        for (int j = 0; j < 7; j++) keep[8*j +: 8] = {8{mask[j]}};
        tdata = data[55:0] & keep;
        code = err ? ERROR :
               !state_in ? (mask == 8'h00 ? IDLE : mask == 8'hFE ? START : ERROR) :
               mask == 8'hFF ? DATA : run ? blk_code_e'(TERM0 + 4'(k)) : ERROR;
        block = code == DATA  ? {data, SYNC_DATA} :
                code == START ? {data[63:8], TYPE_START, SYNC_CTRL} :
                code == IDLE  ? {{8{CTRL_IDLE}}, TYPE_IDLE, SYNC_CTRL} :
                code == ERROR ? {{8{CTRL_ERR}}, TYPE_IDLE, SYNC_CTRL} :
                                {tdata, TERM_TYPES[k], SYNC_CTRL};
        state_out = code == START || code == DATA;
    end
endmodule

// File: rtl/pcs_block_encoder_mb.sv
// pcs_block_encoder_mb: multi-block 64B/66B TX encoder with registered valid/ready output and /E/ counter.
module pcs_block_encoder_mb
    import pcs_pkg::*;
#(
    parameter int NUM_BLOCKS = 1,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    pcs_block_encoder_mb_if.slave bus
);
    logic state;
    logic [NUM_BLOCKS:0] chain;
    blk_code_e code [NUM_BLOCKS];
    logic [66*NUM_BLOCKS-1:0] blk, block_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0] nerr, sum;
    logic valid_q, accept;
    assign chain[0] = state;
    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_lane
        pcs_blk_enc_lane u_lane (
            .state_in(chain[i]),
            .data(bus.data_in[64*i +: 64]),
            .mask(bus.valid_bytes[8*i +: 8]),
            .err(bus.err_in[i]),
            .code(code[i]),
            .block(blk[66*i +: 66]),
            .state_out(chain[i+1])
        );
    end
    always_comb begin
        nerr = '0;
        for (int i = 0; i < NUM_BLOCKS; i++) nerr = nerr + (CNT_W+1)'(code[i] == ERROR);
        sum = {1'b0, cnt} + nerr;
        accept = bus.in_valid && bus.in_ready;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= 1'b0;
            valid_q <= 1'b0;
            block_q <= '0;
            cnt <= '0;
        end else if (accept) begin
            state <= chain[NUM_BLOCKS];
            valid_q <= 1'b1;
            block_q <= blk;
            cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
    assign bus.in_ready = !valid_q || bus.out_ready;
    assign bus.out_valid = valid_q;
    assign bus.block_out = block_q;
    assign bus.err_count = cnt;
endmodule
